// File: rtl/music_pkg.sv
// Shared types and the song address table for the buzzer request front-end.
// SONG_START/SONG_STOP are generated alongside Music.list; the stop address is exclusive.
package music_pkg;

  localparam int SONG_COUNT = 16;
  localparam int NOTE_W     = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    PLAY,
    GAP
  } state_t;

  localparam logic [NOTE_W-1:0] SONG_START [SONG_COUNT] = '{
    12'h000, 12'h010, 12'h020, 12'h030, 12'h040, 12'h060, 12'h080, 12'h0A0,
    12'h0C0, 12'h0E0, 12'h100, 12'h120, 12'h140, 12'h160, 12'h180, 12'hFF0
  };

  // Song 3 is intentionally empty; song 15 wraps through the top of the ROM.
  localparam logic [NOTE_W-1:0] SONG_STOP [SONG_COUNT] = '{
    12'h008, 12'h014, 12'h022, 12'h030, 12'h050, 12'h070, 12'h0A0, 12'h0B0,
    12'h0D8, 12'h0F0, 12'h120, 12'h140, 12'h160, 12'h180, 12'h181, 12'h008
  };

  // Note count of a song; modular so that wrapped songs match the player's pc wrap.
  function automatic logic [NOTE_W-1:0] song_len(input logic [NOTE_W-1:0] first,
                                                 input logic [NOTE_W-1:0] bound);
    return bound - first;
  endfunction

endpackage

// File: rtl/music_sequencer_song_fifo.sv
// Small request FIFO of song ids with flush; flush beats push, and push+pop is allowed when full.
module song_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (srst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

endmodule

// File: rtl/music_sequencer.sv
// Buzzer request front-end: queues song requests, turns ids into ROM address ranges and
// times playback itself, since the player reports no completion.
module music_sequencer
  import music_pkg::*;
#(
  parameter int DIV       = 3000000,
  parameter int DEPTH     = 4,
  parameter int GAP_NOTES = 2
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_song,
  input  logic              req_urgent,
  input  logic              cancel,
  output logic              start,
  output logic [NOTE_W-1:0] start_addr,
  output logic [NOTE_W-1:0] stop_addr,
  output logic              interrupt,
  output logic              busy,
  output logic [2:0]        queue_count
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state_reg;
  logic [3:0]        cur_song_reg;
  logic              pending_reg;
  logic [NOTE_W-1:0] len_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [NOTE_W:0]   note_reg;
  logic              start_reg;
  logic              interrupt_reg;
  logic [NOTE_W-1:0] start_addr_reg;
  logic [NOTE_W-1:0] stop_addr_reg;

  logic              accept;
  logic              urgent_accept;
  logic              normal_accept;
  logic              flush;
  logic              fifo_pop;
  logic [3:0]        fifo_dout;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              div_wrap;
  logic [NOTE_W:0]   note_inc;
  logic [NOTE_W-1:0] rom_start;
  logic [NOTE_W-1:0] rom_stop;

  assign req_ready     = ~cancel & (req_urgent | ~fifo_full);
  assign accept        = req_valid & req_ready;
  assign urgent_accept = accept & req_urgent;
  assign normal_accept = accept & ~req_urgent;
  assign flush         = cancel | urgent_accept;
  assign fifo_pop      = (state_reg == IDLE) & ~fifo_empty & ~flush;

  assign rom_start = SONG_START[cur_song_reg];
  assign rom_stop  = SONG_STOP[cur_song_reg];
  assign div_wrap  = (div_reg == DIV_W'(DIV - 1));
  assign note_inc  = note_reg + (NOTE_W+1)'(1);

  song_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (4)
  ) u_fifo (
    .clk   (clk),
    .srst  (srst),
    .push  (normal_accept),
    .pop   (fifo_pop),
    .flush (flush),
    .din   (req_song),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg      <= IDLE;
      cur_song_reg   <= '0;
      pending_reg    <= 1'b0;
      len_reg        <= '0;
      div_reg        <= '0;
      note_reg       <= '0;
      start_reg      <= 1'b0;
      interrupt_reg  <= 1'b0;
      start_addr_reg <= '0;
      stop_addr_reg  <= '0;
    end else begin
      start_reg     <= 1'b0;
      interrupt_reg <= 1'b0;
      if (cancel) begin
        state_reg     <= IDLE;
        pending_reg   <= 1'b0;
        interrupt_reg <= 1'b1;
      end else if (urgent_accept) begin
        // LOAD waits out the interrupt cycle so start lands two cycles after it.
        cur_song_reg  <= req_song;
        pending_reg   <= 1'b1;
        interrupt_reg <= 1'b1;
        state_reg     <= LOAD;
      end else begin
        case (state_reg)
          IDLE: begin
            if (fifo_pop) begin
              cur_song_reg <= fifo_dout;
              state_reg    <= LOAD;
            end
          end
          LOAD: begin
            if (pending_reg) begin
              pending_reg <= 1'b0;
            end else if (rom_start == rom_stop) begin
              state_reg <= IDLE;
            end else begin
              start_addr_reg <= rom_start;
              stop_addr_reg  <= rom_stop;
              len_reg        <= song_len(rom_start, rom_stop);
              start_reg      <= 1'b1;
              state_reg      <= START;
            end
          end
          START: begin
            div_reg   <= '0;
            note_reg  <= '0;
            state_reg <= PLAY;
          end
          PLAY: begin
            // One extra note of slack covers the player's free-running divider phase.
            if (div_wrap) begin
              div_reg <= '0;
              if (note_inc == ({1'b0, len_reg} + (NOTE_W+1)'(1))) begin
                note_reg  <= '0;
                state_reg <= (GAP_NOTES == 0) ? IDLE : GAP;
              end else begin
                note_reg <= note_inc;
              end
            end else begin
              div_reg <= div_reg + DIV_W'(1);
            end
          end
          GAP: begin
            if (div_wrap) begin
              div_reg <= '0;
              if (note_inc == (NOTE_W+1)'(GAP_NOTES)) begin
                note_reg  <= '0;
                state_reg <= IDLE;
              end else begin
                note_reg <= note_inc;
              end
            end else begin
              div_reg <= div_reg + DIV_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign start       = start_reg;
  assign interrupt   = interrupt_reg;
  assign start_addr  = start_addr_reg;
  assign stop_addr   = stop_addr_reg;
  assign busy        = (state_reg != IDLE);
  assign queue_count = 3'(fifo_count);

endmodule

// File: tb/tb_music_sequencer.sv
// Directed bench for music_sequencer: expected start addresses are queued as requests go in
// and popped by a monitor whenever the DUT pulses start.
module tb_music_sequencer;

  localparam int DIV       = 4;
  localparam int DEPTH     = 4;
  localparam int GAP_NOTES = 2;

  logic        clk = 1'b0;
  logic        srst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_song;
  logic        req_urgent;
  logic        cancel;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] stop_addr;
  logic        interrupt;
  logic        busy;
  logic [2:0]  queue_count;

  music_sequencer #(
    .DIV       (DIV),
    .DEPTH     (DEPTH),
    .GAP_NOTES (GAP_NOTES)
  ) dut (
    .clk         (clk),
    .srst        (srst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_song    (req_song),
    .req_urgent  (req_urgent),
    .cancel      (cancel),
    .start       (start),
    .start_addr  (start_addr),
    .stop_addr   (stop_addr),
    .interrupt   (interrupt),
    .busy        (busy),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_fail = 0;
  int          n_total = 0;
  int          n_starts = 0;
  int          cyc = 0;
  logic [23:0] exp_q [$];
  int          start_cyc [$];
  logic [23:0] sb_head;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] tb_first(input int s);
    case (s)
      1: return 12'h010;
      2: return 12'h020;
      3: return 12'h030;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] tb_bound(input int s);
    case (s)
      1: return 12'h014;
      2: return 12'h022;
      3: return 12'h030;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive one request for a cycle; the scoreboard learns what start it should produce.
  task automatic send(input int song, input logic urg);
    req_valid  = 1'b1;
    req_song   = 4'(song);
    req_urgent = urg;
    #1;
    check($sformatf("req_ready_song%0d", song), 32'(req_ready), 1);
    if (urg) exp_q.delete();
    if (tb_first(song) != tb_bound(song)) exp_q.push_back({tb_first(song), tb_bound(song)});
    tick();
    req_valid  = 1'b0;
    req_urgent = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n0 = n_starts;
    int n  = 0;
    while (n_starts == n0 && n < budget) begin
      tick();
      n++;
    end
    check(tag, n_starts, n0 + 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((busy || queue_count != 3'd0) && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'({busy, queue_count}), 0);
  endtask

  always @(negedge clk) begin
    if (start === 1'b1) begin
      n_starts++;
      start_cyc.push_back(cyc);
      check("start_with_interrupt", 32'(interrupt), 0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(start), 0);
      end else begin
        sb_head = exp_q.pop_front();
        check("start_addr", 32'(start_addr), 32'(sb_head[23:12]));
        check("stop_addr", 32'(stop_addr), 32'(sb_head[11:0]));
      end
    end
  end

  initial begin
    int busy_len;
    int idx0;
    int n0;
    int n;
    int order [5] = '{2, 1, 2, 1, 2};

    srst       = 1'b1;
    req_valid  = 1'b1;
    req_song   = 4'd1;
    req_urgent = 1'b0;
    cancel     = 1'b0;
    repeat (3) tick();
    check("rst_start", 32'(start), 0);
    check("rst_interrupt", 32'(interrupt), 0);
    check("rst_start_addr", 32'(start_addr), 0);
    check("rst_stop_addr", 32'(stop_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_qcount", 32'(queue_count), 0);
    req_valid = 1'b0;
    srst      = 1'b0;
    tick();
    check("post_rst_qcount", 32'(queue_count), 0);
    check("post_rst_busy", 32'(busy), 0);

    // Single song from IDLE: LOAD + START + 5 notes + 2 gap notes of busy.
    send(1, 1'b0);
    n = 0;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    busy_len = 0;
    while (busy && busy_len < 100) begin
      busy_len++;
      tick();
    end
    check("busy_cycles", busy_len, 1 + 1 + 5 * DIV + GAP_NOTES * DIV);
    check("song1_starts", n_starts, 1);
    check("song1_sb_empty", exp_q.size(), 0);

    // Fill the queue while song 2 plays; the fifth request must be refused.
    send(2, 1'b0);
    wait_start("fill_first_start", 20);
    idx0 = start_cyc.size() - 1;
    send(1, 1'b0);
    send(2, 1'b0);
    send(1, 1'b0);
    send(2, 1'b0);
    check("fill_qcount", 32'(queue_count), 4);
    req_valid = 1'b1;
    req_song  = 4'd1;
    #1;
    check("full_ready", 32'(req_ready), 0);
    tick();
    req_valid = 1'b0;
    check("full_qcount", 32'(queue_count), 4);
    wait_idle("fill_drain", 600);
    check("fill_start_count", start_cyc.size(), idx0 + 5);
    for (int i = 0; i < 4; i++) begin
      if (idx0 + i + 1 < start_cyc.size()) begin
        check($sformatf("gap_delta%0d", i), start_cyc[idx0 + i + 1] - start_cyc[idx0 + i],
              (32'(tb_bound(order[i]) - tb_first(order[i])) + 1) * DIV + GAP_NOTES * DIV + 3);
      end
    end

    // Empty song is skipped; the following song still plays.
    n0 = n_starts;
    send(3, 1'b0);
    send(2, 1'b0);
    wait_idle("empty_drain", 200);
    check("empty_skip_starts", n_starts, n0 + 1);

    // Urgent pre-emption mid-song with another song queued.
    n0 = n_starts;
    send(1, 1'b0);
    send(2, 1'b0);
    wait_start("urg_first_start", 20);
    repeat (3) tick();
    send(1, 1'b1);
    check("urg_interrupt", 32'(interrupt), 1);
    check("urg_qcount", 32'(queue_count), 0);
    check("urg_no_start", 32'(start), 0);
    tick();
    check("urg_int_drop", 32'(interrupt), 0);
    check("urg_start_wait", 32'(start), 0);
    tick();
    check("urg_start", 32'(start), 1);
    wait_idle("urg_drain", 200);
    check("urg_start_count", n_starts, n0 + 2);
    check("urg_sb_empty", exp_q.size(), 0);

    // Cancel beats a same-cycle request.
    send(1, 1'b0);
    wait_start("cancel_first_start", 20);
    repeat (4) tick();
    cancel    = 1'b1;
    req_valid = 1'b1;
    req_song  = 4'd2;
    #1;
    check("cancel_ready", 32'(req_ready), 0);
    exp_q.delete();
    tick();
    cancel    = 1'b0;
    req_valid = 1'b0;
    check("cancel_interrupt", 32'(interrupt), 1);
    check("cancel_busy", 32'(busy), 0);
    check("cancel_qcount", 32'(queue_count), 0);
    n0 = n_starts;
    repeat (60) tick();
    check("cancel_no_start", n_starts, n0);
    check("cancel_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
